// File: rtl/cpu_bus_pkg.sv
// Shared encodings for the cache-to-bridge SRAM-like bus: arbiter states, port ids, size codes.
// No logic; imported by the arbiter and its pick sub-block.
// Not applicable (package only).
package cpu_bus_pkg;

    localparam logic [1:0] ARB_IDLE = 2'b00;
    localparam logic [1:0] ARB_ADDR = 2'b01;
    localparam logic [1:0] ARB_DATA = 2'b10;

    localparam logic PORT_INST = 1'b0;
    localparam logic PORT_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/cache_bus_arbiter_pick.sv
// Chooses which cache gets the bus when both request (ARB_ROUND_ROBIN_EN: alternate, else dcache wins).
// Latency: 0 cycles, pick is combinational from the two requests (plus last_served in round-robin builds).
// Backpressure: none; the loser simply keeps its request high until picked.
module arb_pick
    import cpu_bus_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic inst_req,
    input  logic data_req,
    input  logic hs_vld,
    input  logic hs_port,
    output logic pick
);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_served;

    // Remember whoever last had its address accepted; that port loses the next conflict.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_served <= PORT_INST;
        end else if (hs_vld) begin
            last_served <= hs_port;
        end
    end

    always_comb begin
        pick = PORT_INST;
        if (inst_req && data_req) begin
            pick = ~last_served;
        end else if (data_req) begin
            pick = PORT_DATA;
        end
    end
`else
    logic unused_pick_in;

    assign unused_pick_in = ^{clk, resetn, inst_req, hs_vld, hs_port};

    // Fixed priority: dcache wins any conflict, so icache can starve under continuous dcache traffic.
    assign pick = data_req ? PORT_DATA : PORT_INST;
`endif

endmodule

// File: rtl/cache_bus_arbiter.sv
// Shares one SRAM-like bridge port between icache and dcache; owner held addr->data; ARB_ROUND_ROBIN_EN selects round-robin.
// Latency: 0-cycle arbitration (request forwarded the cycle it arrives), at least 1 cycle addr_ok->data_ok.
// Backpressure: bridge addr_ok stalls the owner in ADDR; non-owner sees addr_ok=0 and must hold its request.
module cache_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  inst_req,
    input  logic                  inst_wr,
    input  logic [1:0]            inst_size,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic [DATA_WIDTH-1:0] inst_wdata,
    output logic [DATA_WIDTH-1:0] inst_rdata,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,

    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [1:0]            data_size,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,

    output logic                  bus_req,
    output logic                  bus_wr,
    output logic [1:0]            bus_size,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_addr_ok,
    input  logic                  bus_data_ok,

    output logic                  grant_data,
    output logic                  busy
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       owner;
    logic       pick;
    logic       sel;
    logic       sel_req;
    logic       addr_phase;
    logic       in_data;
    logic       addr_hs;
    logic       proto_err;

    arb_pick u_pick (
        .clk      (clk),
        .resetn   (resetn),
        .inst_req (inst_req),
        .data_req (data_req),
        .hs_vld   (addr_hs),
        .hs_port  (sel),
        .pick     (pick)
    );

    // In IDLE the fresh pick drives the bus (zero-cycle arbitration); afterwards the latched owner does.
    assign sel        = (state == ARB_IDLE) ? pick : owner;
    assign sel_req    = (sel == PORT_DATA) ? data_req : inst_req;
    assign addr_phase = (state == ARB_IDLE) || (state == ARB_ADDR);
    assign in_data    = (state == ARB_DATA);

    // Gated by resetn so every request-side output drops the same cycle reset is asserted.
    assign bus_req    = resetn & addr_phase & sel_req;
    assign addr_hs    = bus_req & bus_addr_ok;
    assign grant_data = resetn & sel;
    assign busy       = (state != ARB_IDLE);

    assign bus_wr    = (sel == PORT_DATA) ? data_wr    : inst_wr;
    assign bus_size  = (sel == PORT_DATA) ? data_size  : inst_size;
    assign bus_addr  = (sel == PORT_DATA) ? data_addr  : inst_addr;
    assign bus_wdata = (sel == PORT_DATA) ? data_wdata : inst_wdata;

    assign inst_addr_ok = addr_hs & (sel == PORT_INST);
    assign data_addr_ok = addr_hs & (sel == PORT_DATA);

    assign inst_data_ok = in_data & bus_data_ok & (owner == PORT_INST);
    assign data_data_ok = in_data & bus_data_ok & (owner == PORT_DATA);
    assign inst_rdata   = (in_data && owner == PORT_INST) ? bus_rdata : '0;
    assign data_rdata   = (in_data && owner == PORT_DATA) ? bus_rdata : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (addr_hs) begin
                    state_nxt = ARB_DATA;
                end else if (sel_req) begin
                    state_nxt = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                // Owner withdrawing before the bridge accepts abandons the transaction.
                if (!sel_req) begin
                    state_nxt = ARB_IDLE;
                end else if (addr_hs) begin
                    state_nxt = ARB_DATA;
                end
            end
            ARB_DATA: begin
                if (bus_data_ok) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ARB_IDLE;
            owner <= PORT_INST;
        end else begin
            state <= state_nxt;
            if (state == ARB_IDLE) begin
                owner <= pick;
            end
        end
    end

    // Sticky marker for a bridge data_ok outside DATA; the pulse itself is dropped, never forwarded.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            proto_err <= 1'b0;
        end else if (bus_data_ok && !in_data) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Randomized bench for cache_bus_arbiter: directed scenarios plus random cache/bridge agents.
// A cycle-level reference model derived from the arbitration rules predicts every output.
module tb_cache_bus_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0;
    logic [1:0]  inst_size = 0, data_size = 0, bus_size;
    logic [31:0] inst_addr = 0, inst_wdata = 0, data_addr = 0, data_wdata = 0;
    logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        bus_req, bus_wr, grant_data, busy;
    logic [31:0] bus_rdata = 0;
    logic        bus_addr_ok = 0, bus_data_ok = 0;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: is a transaction waiting for data, is an owner holding the address phase.
    logic m_open, m_claim, m_owner, m_last;
    // Order of address grants as actually observed on the DUT outputs (1=dcache).
    logic dut_log[$];
    logic        obs_busy, obs_grant, obs_iaok, obs_idok, obs_ddok;
    logic [31:0] obs_irdata;

    always #5 clk = ~clk;

    cache_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok),
        .grant_data(grant_data), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic winner(input logic ir, input logic dr, input logic last);
        if (RR_EN && ir && dr) return !last;
        return dr;
    endfunction

    task automatic model_reset();
        m_open = 0; m_claim = 0; m_owner = 0; m_last = 0;
        dut_log.delete();
    endtask

    // One clock: inputs were driven at posedge+1; check at negedge, advance model, return at posedge+1.
    task automatic step(output logic hs, output logic own, output logic dk, output logic dk_port);
        logic ereq, e_iaok, e_daok, e_idok, e_ddok;
        logic [31:0] e_ird, e_drd;
        @(negedge clk);
        e_iaok = 0; e_daok = 0; e_idok = 0; e_ddok = 0; e_ird = 0; e_drd = 0;
        hs = 0; dk = 0; dk_port = m_owner; ereq = 0;
        if (m_open) begin
            own = m_owner;
            dk  = bus_data_ok;
            if (own) begin e_ddok = bus_data_ok; e_drd = bus_rdata; end
            else     begin e_idok = bus_data_ok; e_ird = bus_rdata; end
        end else begin
            own    = m_claim ? m_owner : winner(inst_req, data_req, m_last);
            ereq   = own ? data_req : inst_req;
            hs     = ereq & bus_addr_ok;
            e_iaok = hs & ~own;
            e_daok = hs & own;
        end
        check("bus_req", bus_req, ereq);
        check("grant_data", grant_data, own);
        check("busy", busy, m_open | m_claim);
        check("inst_addr_ok", inst_addr_ok, e_iaok);
        check("data_addr_ok", data_addr_ok, e_daok);
        check("inst_data_ok", inst_data_ok, e_idok);
        check("data_data_ok", data_data_ok, e_ddok);
        check("inst_rdata", inst_rdata, e_ird);
        check("data_rdata", data_rdata, e_drd);
        if (ereq) begin
            check("bus_addr", bus_addr, own ? data_addr : inst_addr);
            check("bus_wdata", bus_wdata, own ? data_wdata : inst_wdata);
            check("bus_ctl", {bus_wr, bus_size}, own ? {data_wr, data_size} : {inst_wr, inst_size});
        end
        obs_busy = busy; obs_grant = grant_data; obs_iaok = inst_addr_ok;
        obs_idok = inst_data_ok; obs_ddok = data_data_ok; obs_irdata = inst_rdata;
        if (inst_addr_ok) dut_log.push_back(1'b0);
        if (data_addr_ok) dut_log.push_back(1'b1);
        if (m_open) begin
            if (bus_data_ok) m_open = 0;
        end else if (hs) begin
            m_open = 1; m_claim = 0; m_owner = own; m_last = own;
        end else begin
            m_claim = ereq;
            m_owner = own;
        end
        @(posedge clk);
        #1;
    endtask

    // Random cache agents and bridge; stops after `cycles` or once `stop_grants` grants are seen.
    task automatic run(input int cycles, input int p_req, input int p_aok, input int max_lat,
                       input bit cont, input int stop_grants);
        bit pend_i = 0, pend_d = 0, wait_i = 0, wait_d = 0;
        int br_cnt = 0;
        logic hs, own, dk, dkp;
        for (int c = 0; c < cycles + 8; c++) begin
            if (c >= cycles || dut_log.size() >= stop_grants) begin
                pend_i = 0; pend_d = 0;
            end else begin
                if (!pend_i && !wait_i && (cont || $urandom_range(99) < p_req)) begin
                    pend_i = 1; inst_addr = $urandom; inst_size = 2'($urandom_range(2));
                end
                if (!pend_d && !wait_d && (cont || $urandom_range(99) < p_req)) begin
                    pend_d = 1; data_addr = $urandom; data_size = 2'($urandom_range(2));
                    data_wr = 1'($urandom_range(1)); data_wdata = $urandom;
                end
                if (!cont && pend_i && $urandom_range(99) < 2) pend_i = 0;
                if (!cont && pend_d && $urandom_range(99) < 2) pend_d = 0;
            end
            inst_req    = pend_i;
            data_req    = pend_d;
            bus_data_ok = (br_cnt == 1);
            bus_addr_ok = (br_cnt == 0) && ($urandom_range(99) < p_aok);
            bus_rdata   = $urandom;
            step(hs, own, dk, dkp);
            if (br_cnt > 0) br_cnt--;
            if (hs) begin
                br_cnt = $urandom_range(max_lat, 1);
                if (own) begin pend_d = 0; wait_d = 1; end
                else     begin pend_i = 0; wait_i = 1; end
            end
            if (dk) begin
                if (dkp) wait_d = 0;
                else     wait_i = 0;
            end
        end
        bus_addr_ok = 0; bus_data_ok = 0;
    endtask

    initial begin
        logic hs, own, dk, dkp;
        int cnt;
        model_reset();
        inst_req = 1; data_req = 1; bus_addr_ok = 1;
        #3;
        check("rst_bus_req", bus_req, 0);
        check("rst_grant", grant_data, 0);
        check("rst_busy", busy, 0);
        check("rst_aok", {inst_addr_ok, data_addr_ok}, 0);
        check("rst_rdata", inst_rdata | data_rdata, 0);
        inst_req = 0; data_req = 0; bus_addr_ok = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1;

        // 1: lone icache read, data three cycles after address
        inst_req = 1; inst_addr = 32'hBFC00000; inst_size = 2'b10; bus_addr_ok = 1;
        step(hs, own, dk, dkp);
        check("t1_addr_ok", obs_iaok, 1);
        inst_req = 0; bus_addr_ok = 0;
        step(hs, own, dk, dkp);
        step(hs, own, dk, dkp);
        bus_data_ok = 1; bus_rdata = 32'h3C08BFC0;
        step(hs, own, dk, dkp);
        check("t1_data_ok", obs_idok, 1);
        check("t1_rdata", obs_irdata, 32'h3C08BFC0);
        check("t1_dcache_quiet", obs_ddok, 0);
        bus_data_ok = 0;

        // 2: simultaneous requests, bridge accepts immediately
        dut_log.delete();
        inst_req = 1; data_req = 1; bus_addr_ok = 1;
        step(hs, own, dk, dkp);
        data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        step(hs, own, dk, dkp);
        bus_addr_ok = 1; bus_data_ok = 0;
        step(hs, own, dk, dkp);
        inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        step(hs, own, dk, dkp);
        bus_data_ok = 0;
        check("t2_grants", dut_log.size(), 2);
        if (dut_log.size() == 2) begin
            check("t2_first", dut_log[0], 1);
            check("t2_second", dut_log[1], 0);
        end

        // 3: dcache write held off by the bridge while icache also requests
        data_req = 1; data_wr = 1; data_addr = 32'h80000010; data_wdata = 32'h12345678;
        data_size = 2'b10; inst_req = 1; inst_addr = 32'hBFC00040; cnt = 0;
        dut_log.delete();
        for (int i = 0; i < 5; i++) begin
            bus_addr_ok = (i == 4);
            step(hs, own, dk, dkp);
            if (obs_busy && obs_grant) cnt++;
        end
        check("t3_addr_cycles", cnt, 4);
        check("t3_first_grant", dut_log.size() > 0 ? dut_log[0] : 1'bx, 1);
        data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        step(hs, own, dk, dkp);
        bus_addr_ok = 1; bus_data_ok = 0;
        step(hs, own, dk, dkp);
        inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        step(hs, own, dk, dkp);
        bus_data_ok = 0; data_wr = 0;

        // 4: spurious data_ok while idle
        check("t4_err_before", dut.proto_err, 0);
        bus_data_ok = 1; bus_rdata = 32'hDEADBEEF;
        step(hs, own, dk, dkp);
        bus_data_ok = 0;
        check("t4_err_flag", dut.proto_err, 1);
        check("t4_idle", busy, 0);

        // 5: reset asserted in the middle of DATA
        inst_req = 1; bus_addr_ok = 1;
        step(hs, own, dk, dkp);
        inst_req = 0; data_req = 1; bus_addr_ok = 1; bus_rdata = 32'hFFFFFFFF;
        #2 resetn = 0;
        #1;
        check("t5_bus_req", bus_req, 0);
        check("t5_busy", busy, 0);
        check("t5_grant", grant_data, 0);
        check("t5_aok", {inst_addr_ok, data_addr_ok}, 0);
        check("t5_rdata", inst_rdata | data_rdata, 0);
        data_req = 0; bus_addr_ok = 0;
        @(posedge clk);
        #1 resetn = 1;
        model_reset();
        data_req = 1; data_addr = 32'h80001000; bus_addr_ok = 1;
        step(hs, own, dk, dkp);
        check("t5_after_reset", dut_log.size(), 1);
        data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        step(hs, own, dk, dkp);
        bus_data_ok = 0;

        // 6: both ports requesting continuously for 20 transactions
        dut_log.delete();
        run(200, 0, 100, 1, 1'b1, 20);
        check("t6_count", dut_log.size(), 20);
        cnt = 0;
        foreach (dut_log[i]) cnt += int'(dut_log[i]);
`ifdef ARB_ROUND_ROBIN_EN
        check("t6_dcache_grants", cnt, 10);
        for (int i = 1; i < dut_log.size(); i++) check("t6_alternate", dut_log[i], !dut_log[i-1]);
`else
        check("t6_dcache_grants", cnt, dut_log.size());
`endif

        // Random traffic: random requests, abandons, addr_ok stalls and data latencies
        run(3000, 30, 50, 3, 1'b0, 1 << 30);
        run(1500, 80, 25, 4, 1'b0, 1 << 30);
        check("final_idle", busy, 0);
        check("no_proto_err", dut.proto_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
